instruction_prefetch_queue: RTL
===============================

Name: instruction_prefetch_queue

Overview:
Fetch stage directly upstream of the instruction decoder. It generates sequential fetch addresses and issues single-outstanding word reads to instruction memory. Returned words are buffered with their PC in a small FIFO, and the queue head is presented as IR to the decode stage. It supports a redirect/flush from execute (taken branch, CALL, interrupt) that discards buffered and in-flight instructions.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
ADDRESS_WIDTH, 32, byte-address width of PC / memory address
RESET_VECTOR, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
memAddress  output  ADDRESS_WIDTH  word-aligned fetch address
memRead  output  1  read request; held with stable memAddress until memReady
memData  input  32  instruction word, valid when memReady=1
memReady  input  1  completes the pending read this cycle
IR  output  32  instruction at queue head
IRPc  output  ADDRESS_WIDTH  address of IR
IRValid  output  1  queue non-empty, IR/IRPc valid
IRTaken  input  1  decoder consumes head this cycle (effective only with IRValid)
flush  input  1  redirect request (single-cycle pulse)
flushAddress  input  ADDRESS_WIDTH  new fetch address; bits [1:0] ignored/forced 0
fetchStallCycles  output  32  only with PREFETCH_STATS_EN

Behaviour:
- Reset values: memRead=0, memAddress=RESET_VECTOR, IR=0, IRPc=0, IRValid=0, queue count=0, state=FETCH, fetchStallCycles=0. Reset mid-operation drops the queue and any pending read with no drain. Memory must tolerate memRead falling on reset.
- FSM states: FETCH and DRAIN.
- FETCH:
  - memRead=1 whenever (count + pending) < DEPTH.
  - A completed read (memRead&&memReady) pushes {memData, memAddress}, and memAddress advances by 4 at the same edge.
  - If room remains, memRead stays high next cycle; back-to-back reads at 1/cycle are possible when memReady is tied high.
- DRAIN: entered on flush while a read is pending and memReady=0.
  - memRead/memAddress stay held until memReady; the returned data is discarded.
  - flushAddress is latched on entry. On memReady, memAddress=latched address and state returns to FETCH.
  - Another flush in DRAIN overwrites the latched address.
- Flush in FETCH with no pending read, or with memReady=1 in the same cycle: returned data is discarded, and next cycle memAddress=flushAddress with memRead=1.
- Flush priority: flush beats push and pop in the same cycle. The queue is empty and IRValid=0 the next cycle, and IRTaken is ignored in the flush cycle.
- Latency: a word accepted at edge N is visible as IR/IRValid after edge N (registered head). Minimum flush-to-IRValid latency is 2 cycles with zero-wait memory.
- Queue:
  - Push and pop in the same cycle are allowed at any count.
  - Full: no new request is issued, so there is no overflow.
  - Empty with IRTaken=1 is ignored.
  - Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits.
- PC arithmetic: modulo 2^ADDRESS_WIDTH, so 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
PREFETCH_STATS_EN:
- Defined: fetchStallCycles increments (saturating at 32'hFFFF_FFFF) on every cycle with IRValid=0 and not in reset. It clears on reset only.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch state encoding (FETCH, DRAIN)
  - INSTRUCTION_WIDTH=32
  - PC_INCREMENT=4
  - queue entry struct {pc, instruction}
- One sub-module, fetch_queue: synchronous FIFO with push/pop/clear, count, and registered head. The FSM and address logic stay in the top.

Test Plan:
- Reset release, memReady tied 1, IRTaken=1 -> memAddress 0,4,8,12 on consecutive cycles; IRValid rises one cycle after first memReady with IRPc=0.
- IRTaken=0, memReady=1 -> exactly 4 reads (0..12), then memRead=0; a single IRTaken pops PC 0 and a read of 16 is issued next cycle.
- Read to 8 pending with memReady=0, then flush to 32'h100 -> DRAIN; memReady after 3 cycles discards data, next memAddress=32'h100, and no instruction from 8 appears on IR.
- flush to 32'h203 in the same cycle as memReady and IRTaken -> queue empties, next memAddress=32'h200, queue count unaffected by that pop/push.
- Reset asserted for one cycle with queue at 3 entries and a pending read -> memRead=0, IRValid=0, then fetch restarts at RESET_VECTOR.
- PREFETCH_STATS_EN defined, memReady=0 for 10 cycles after reset -> fetchStallCycles=10; a flush later adds the empty-queue cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding, widths and queue entry layout.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int PC_INCREMENT      = 4;
  localparam int PC_WIDTH          = 32;

  typedef struct packed {
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instruction} entries with clear and a registered head entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH       = 4,
  localparam int PTR_WIDTH   = $clog2(DEPTH),
  localparam int COUNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  queue_entry_t           push_entry,
  output queue_entry_t           head,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   valid
);

  queue_entry_t          mem [DEPTH];
  queue_entry_t          head_q;
  queue_entry_t          head_next;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr_inc;
  logic                  do_push;
  logic                  do_pop;

  assign valid      = (count != '0);
  assign do_push    = push && !clear && (count != COUNT_WIDTH'(DEPTH));
  assign do_pop     = pop && !clear && valid;
  assign rd_ptr_inc = rd_ptr + PTR_WIDTH'(1);
  assign head       = head_q;

  // Head is precomputed so IR comes straight from a flop; a push into an emptying queue bypasses storage.
  always_comb begin
    // NOTE: default assignment first so every path assigns head_next and no latch is inferred.
    head_next = head_q;
    if (do_pop) begin
      if (count > COUNT_WIDTH'(1)) head_next = mem[rd_ptr_inc];
      else if (do_push)            head_next = push_entry;
      else                         head_next = '0;
    end else if (!valid && do_push) begin
      head_next = push_entry;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      count  <= count + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
      head_q <= head_next;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher with single-outstanding reads, flush/redirect and a decode-facing queue.
// Optional PREFETCH_STATS_EN adds the fetchStallCycles counter of cycles with no valid instruction.
module instruction_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                       DEPTH         = 4,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDRESS_WIDTH-1:0]     memAddress,
  output logic                         memRead,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  input  logic                         memReady,
  output logic [INSTRUCTION_WIDTH-1:0] IR,
  output logic [ADDRESS_WIDTH-1:0]     IRPc,
  output logic                         IRValid,
  input  logic                         IRTaken,
  input  logic                         flush,
  input  logic [ADDRESS_WIDTH-1:0]     flushAddress
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]                  fetchStallCycles
`endif
);

  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

  fetch_state_t             state_q;
  fetch_state_t             state_next;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic [ADDRESS_WIDTH-1:0] redirect_q;
  logic [ADDRESS_WIDTH-1:0] redirect_next;
  logic [ADDRESS_WIDTH-1:0] flush_aligned;
  logic                     read_q;
  logic                     read_next;
  logic                     complete;
  logic                     push;
  logic                     pop;
  logic [COUNT_WIDTH-1:0]   count;
  logic [COUNT_WIDTH-1:0]   count_after;
  queue_entry_t             push_entry;
  queue_entry_t             head;

  assign flush_aligned = flushAddress & ~ADDRESS_WIDTH'(3);
  assign complete      = read_q && memReady;
  // Flush wins over both ends of the queue; data returning during DRAIN belongs to the old stream.
  assign push          = complete && (state_q == FETCH) && !flush;
  assign pop           = IRTaken && IRValid && !flush;
  assign count_after   = count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
  assign push_entry    = '{pc: PC_WIDTH'(addr_q), instruction: memData};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .clear      (flush),
    .push_entry (push_entry),
    .head       (head),
    .count      (count),
    .valid      (IRValid)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      FETCH:   if (flush && read_q && !memReady) state_next = DRAIN;
      DRAIN:   if (memReady)                     state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    addr_next     = addr_q;
    read_next     = read_q;
    redirect_next = redirect_q;
    case (state_q)
      FETCH: begin
        if (flush) begin
          if (read_q && !memReady) begin
            redirect_next = flush_aligned;
          end else begin
            addr_next = flush_aligned;
            read_next = 1'b1;
          end
        end else begin
          if (complete) addr_next = addr_q + ADDRESS_WIDTH'(PC_INCREMENT);
          // Counting the pending read against DEPTH is what makes overflow impossible.
          read_next = (read_q && !memReady) || (count_after < COUNT_WIDTH'(DEPTH));
        end
      end
      DRAIN: begin
        if (flush) redirect_next = flush_aligned;
        if (memReady) begin
          addr_next = flush ? flush_aligned : redirect_q;
          read_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= RESET_VECTOR;
      redirect_q <= RESET_VECTOR;
      read_q     <= 1'b0;
    end else begin
      addr_q     <= addr_next;
      redirect_q <= redirect_next;
      read_q     <= read_next;
    end
  end

  assign memAddress = addr_q;
  assign memRead    = read_q;
  assign IR         = head.instruction;
  assign IRPc       = ADDRESS_WIDTH'(head.pc);

`ifdef PREFETCH_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset)                          stall_q <= '0;
    else if (!IRValid && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign fetchStallCycles = stall_q;
`endif

endmodule
